// File: rtl/uart_loader_ctrl_pkg.sv
// Shared types and byte constants for the UART program loader.
package loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_AH,
        ST_GET_AL,
        ST_GET_LEN,
        ST_WR_DATA,
        ST_WR_CSUM,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_SEND,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_PEND,
        TX_START,
        TX_WAIT
    } tx_state_e;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    // A length byte of zero encodes a full 256-byte transfer.
    function automatic logic [8:0] decode_len(input logic [7:0] b);
        return (b == 8'h00) ? 9'd256 : {1'b0, b};
    endfunction

endpackage

// File: rtl/uart_loader_ctrl_if.sv
// Bundle of UART, memory-port and CPU-control signals around the loader.
interface uart_loader_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;
    logic              mem_own;
    logic              cpu_halt;
    logic              cpu_rst_n;
    logic [4:0]        status;

    modport master (
        input  rx_data, rx_valid, tx_busy, mem_rdata,
        output tx_data, tx_start, mem_addr, mem_wdata, mem_we, mem_own,
               cpu_halt, cpu_rst_n, status
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, mem_rdata,
        input  tx_data, tx_start, mem_addr, mem_wdata, mem_we, mem_own,
               cpu_halt, cpu_rst_n, status
    );
endinterface

// File: rtl/uart_loader_ctrl_tx_seq.sv
// Single-byte UART TX handshake: latch byte, wait for idle line, pulse start, wait for busy to fall.
module loader_tx_seq
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic       done_o,
    output logic       active_o
);
    tx_state_e  state_q, state_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // START always moves to WAIT, so two start pulses can never be adjacent.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_o  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (req_i) begin
                    data_d  = byte_i;
                    state_d = TX_PEND;
                end
            end
            TX_PEND:  if (!tx_busy_i) state_d = TX_START;
            TX_START: state_d = TX_WAIT;
            TX_WAIT: begin
                if (!tx_busy_i) begin
                    done_o  = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            default:  state_d = TX_IDLE;
        endcase
    end

    assign tx_start_o = (state_q == TX_START);
    assign tx_data_o  = data_q;
    assign active_o   = (state_q != TX_IDLE);

endmodule

// File: rtl/uart_loader_ctrl.sv
// UART command loader: halts the CPU, writes/reads program memory, releases via a CPU reset pulse.
// Optional build macro LOADER_CHECKSUM_EN appends a checksum byte to every 'W' command.
module uart_loader_ctrl
    import loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 120000,
    parameter bit HALT_ON_RST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_loader_ctrl_if.master  bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        ah_q, ah_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        len_q, len_d;
    logic [7:0]        resp_q, resp_d;
    logic [7:0]        rd_q, rd_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              halt_q, halt_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              err_q, err_d;
    logic              rx_seen_q, rx_seen_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              tx_req_q, tx_req_d;

    logic              rx;
    logic [7:0]        rx_byte;
    logic [15:0]       addr_full;
    logic [7:0]        csum_sum;
    logic              in_timed;
    logic              tmo_hit;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic              tx_active;
    logic              tx_start;
    logic [7:0]        tx_data;

    assign rx        = bus.rx_valid;
    assign rx_byte   = bus.rx_data;
    assign addr_full = {ah_q, rx_byte};
    assign csum_sum  = csum_q + rx_byte;
    assign in_timed  = (state_q == ST_GET_AH) || (state_q == ST_GET_AL) ||
                       (state_q == ST_GET_LEN) || (state_q == ST_WR_DATA) ||
                       (state_q == ST_WR_CSUM);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_hit   = in_timed && !rx && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign tx_byte   = (state_q == ST_RD_SEND) ? rd_q : resp_q;

    loader_tx_seq u_tx_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (tx_req_q),
        .byte_i     (tx_byte),
        .tx_busy_i  (bus.tx_busy),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .done_o     (tx_done),
        .active_o   (tx_active)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'h00;
            ah_q        <= 8'h00;
            addr_q      <= '0;
            len_q       <= 9'd0;
            resp_q      <= 8'h00;
            rd_q        <= 8'h00;
            csum_q      <= 8'h00;
            tmo_q       <= '0;
            halt_q      <= HALT_ON_RST;
            cpu_rst_n_q <= 1'b1;
            err_q       <= 1'b0;
            rx_seen_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            tx_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ah_q        <= ah_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            resp_q      <= resp_d;
            rd_q        <= rd_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            halt_q      <= halt_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            err_q       <= err_d;
            rx_seen_q   <= rx_seen_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_req_q    <= tx_req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ah_d        = ah_q;
        addr_d      = addr_q;
        len_d       = len_q;
        resp_d      = resp_q;
        rd_d        = rd_q;
        csum_d      = csum_q;
        halt_d      = halt_q;
        cpu_rst_n_d = 1'b1;
        err_d       = err_q;
        rx_seen_d   = rx_seen_q | rx;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tmo_d       = (in_timed && !rx) ? tmo_q + TMO_W'(1) : '0;

        // The CPU leaves halt in the cycle after its reset pulse.
        if (!cpu_rst_n_q) halt_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx) begin
                    case (rx_byte)
                        CMD_H: begin
                            halt_d  = 1'b1;
                            err_d   = 1'b0;
                            resp_d  = ACK;
                            state_d = ST_RESP;
                        end
                        CMD_G: begin
                            cpu_rst_n_d = 1'b0;
                            resp_d      = ACK;
                            state_d     = ST_RESP;
                        end
                        CMD_W, CMD_R: begin
                            cmd_d   = rx_byte;
                            state_d = ST_GET_AH;
                        end
                        default: begin
                            resp_d  = NAK;
                            state_d = ST_RESP;
                        end
                    endcase
                end
            end
            ST_GET_AH: begin
                if (rx) begin
                    ah_d    = rx_byte;
                    csum_d  = rx_byte;
                    state_d = ST_GET_AL;
                end
            end
            ST_GET_AL: begin
                if (rx) begin
                    addr_d  = addr_full[ADDR_W-1:0];
                    csum_d  = csum_sum;
                    state_d = ST_GET_LEN;
                end
            end
            ST_GET_LEN: begin
                if (rx) begin
                    len_d  = decode_len(rx_byte);
                    csum_d = csum_sum;
                    if (!halt_q) begin
                        resp_d  = NAK;
                        state_d = ST_RESP;
                    end else if (cmd_q == CMD_W) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        mem_addr_d = addr_q;
                        state_d    = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_DATA: begin
                if (rx) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = rx_byte;
                    addr_d      = addr_q + ADDR_W'(1);
                    len_d       = len_q - 9'd1;
                    csum_d      = csum_sum;
                    if (len_q == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_WR_CSUM;
`else
                        resp_d  = ACK;
                        state_d = ST_RESP;
`endif
                    end
                end
            end
            ST_WR_CSUM: begin
                if (rx) begin
                    if (csum_sum == 8'h00) begin
                        resp_d = ACK;
                    end else begin
                        resp_d = NAK;
                        err_d  = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RD_ADDR: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                rd_d    = bus.mem_rdata;
                state_d = ST_RD_SEND;
            end
            ST_RD_SEND: begin
                if (tx_done) begin
                    addr_d = addr_q + ADDR_W'(1);
                    len_d  = len_q - 9'd1;
                    if (len_q == 9'd1) begin
                        resp_d  = ACK;
                        state_d = ST_RESP;
                    end else begin
                        mem_addr_d = addr_q + ADDR_W'(1);
                        state_d    = ST_RD_ADDR;
                    end
                end
            end
            ST_RESP:    if (tx_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (tmo_hit) begin
            resp_d  = NAK;
            err_d   = 1'b1;
            tmo_d   = '0;
            state_d = ST_RESP;
        end

        tx_req_d = (state_d != state_q) &&
                   ((state_d == ST_RD_SEND) || (state_d == ST_RESP));
    end

    assign bus.tx_start  = tx_start;
    assign bus.tx_data   = tx_data;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_own   = halt_q;
    assign bus.cpu_halt  = halt_q;
    assign bus.cpu_rst_n = cpu_rst_n_q;
    assign bus.status    = {err_q, halt_q, (state_q != ST_IDLE), rx_seen_q, tx_active};

endmodule
